// File: rtl/shift_pkg.sv
// Shared shift-type codes and sequencer state encoding (also used by the Val2 path).
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational shift slice: shifts/rotates value by k (1..STEP) and reports the last bit out.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STEP       = 1,
  parameter int unsigned K_WIDTH    = $clog2(STEP + 1)
) (
  input  logic [DATA_WIDTH-1:0] value,
  input  shift_t                kind,
  input  logic [K_WIDTH-1:0]    k,
  output logic [DATA_WIDTH-1:0] next_value,
  output logic                  carry
);

  localparam int unsigned W = DATA_WIDTH;

  logic        [W:0]   lsl_full;
  logic        [W:0]   lsr_full;
  logic signed [W:0]   asr_full;
  logic        [W-1:0] ror_val;

  // Widened shifts carry the last bit out in the extra position.
  always_comb begin
    lsl_full   = {1'b0, value} << k;
    lsr_full   = {value, 1'b0} >> k;
    asr_full   = $signed({value, 1'b0}) >>> k;
    ror_val    = (value >> k) | (value << (W - 32'(k)));
    next_value = value;
    carry      = 1'b0;
    case (kind)
      SHIFT_LSL: begin
        next_value = lsl_full[W-1:0];
        carry      = lsl_full[W];
      end
      SHIFT_LSR: begin
        next_value = lsr_full[W:1];
        carry      = lsr_full[0];
      end
      SHIFT_ASR: begin
        next_value = asr_full[W:1];
        carry      = asr_full[0];
      end
      SHIFT_ROR: begin
        next_value = ror_val;
        carry      = lsr_full[0];
      end
      default: begin
        next_value = value;
        carry      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle register-specified shift controller for the EX stage.
// Optional feature macro: SHIFT_SEQ_FLUSH_EN adds a flush input that aborts any operation.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned AMT_WIDTH  = 8,
  parameter int unsigned STEP       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef SHIFT_SEQ_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_value,
  input  logic [AMT_WIDTH-1:0]  req_amount,
  input  logic [1:0]            req_shift,
  input  logic                  req_carry,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_value,
  output logic                  rsp_carry,
  output logic                  busy
);

  localparam int unsigned REM_W = $clog2(DATA_WIDTH + 2);
  localparam int unsigned K_W   = $clog2(STEP + 1);

  state_t                state_q, state_d;
  shift_t                kind_q, kind_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [DATA_WIDTH-1:0] val_q, val_d;
  logic                  carry_q, carry_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  busy_q, busy_d;

  shift_t                req_kind_c;
  logic [31:0]           amt32_c;
  logic [31:0]           ror_mod_c;
  logic [31:0]           n_wide_c;
  logic [REM_W-1:0]      n_eff_c;
  logic [K_W-1:0]        k_c;
  logic                  flush_c;
  logic                  accept_c;
  logic [DATA_WIDTH-1:0] step_value;
  logic                  step_carry;

`ifdef SHIFT_SEQ_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  assign req_kind_c = shift_t'(req_shift);
  assign req_ready  = !flush_c && ((state_q == IDLE) || ((state_q == DONE) && rsp_ready));
  assign accept_c   = req_valid && req_ready;

  // Effective bit count: saturate linear shifts at W+1, fold rotates into 1..W.
  always_comb begin
    amt32_c   = 32'(req_amount);
    ror_mod_c = amt32_c % DATA_WIDTH;
    n_wide_c  = amt32_c;
    if (req_kind_c == SHIFT_ROR) begin
      n_wide_c = ((ror_mod_c == 32'd0) && (amt32_c != 32'd0)) ? DATA_WIDTH : ror_mod_c;
    end else if (amt32_c > DATA_WIDTH + 1) begin
      n_wide_c = DATA_WIDTH + 1;
    end
    n_eff_c = REM_W'(n_wide_c);
  end

  // Bits to move this cycle.
  always_comb begin
    k_c = (32'(rem_q) >= STEP) ? K_W'(STEP) : K_W'(rem_q);
  end

  shift_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .STEP       (STEP),
    .K_WIDTH    (K_W)
  ) u_step (
    .value      (val_q),
    .kind       (kind_q),
    .k          (k_c),
    .next_value (step_value),
    .carry      (step_carry)
  );

  // Next-state, operand load and per-cycle shift.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    rem_d       = rem_q;
    val_d       = val_q;
    carry_d     = carry_q;
    rsp_valid_d = rsp_valid_q;

    case (state_q)
      IDLE: begin
        rsp_valid_d = 1'b0;
      end
      SHIFT: begin
        val_d   = step_value;
        carry_d = step_carry;
        rem_d   = rem_q - REM_W'(k_c);
        if (rem_q == REM_W'(k_c)) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase

    if (accept_c) begin
      kind_d      = req_kind_c;
      rem_d       = n_eff_c;
      val_d       = req_value;
      carry_d     = req_carry;
      state_d     = (n_eff_c == '0) ? DONE : SHIFT;
      rsp_valid_d = (n_eff_c == '0);
    end

    if (flush_c) begin
      state_d     = IDLE;
      rem_d       = '0;
      rsp_valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      kind_q      <= SHIFT_LSL;
      rem_q       <= '0;
      val_q       <= '0;
      carry_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      rem_q       <= rem_d;
      val_q       <= val_d;
      carry_q     <= carry_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_value = val_q;
  assign rsp_carry = carry_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomised self-checking bench for shift_sequencer against an ARM barrel-shift reference.
module tb_shift_sequencer;

  localparam int unsigned W    = 32;
  localparam int unsigned AW   = 8;
  localparam int unsigned STEP = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_value;
  logic [AW-1:0] req_amount;
  logic [1:0]    req_shift;
  logic          req_carry;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_value;
  logic          rsp_carry;
  logic          busy;
`ifdef SHIFT_SEQ_FLUSH_EN
  logic          flush;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  shift_sequencer #(
    .DATA_WIDTH (W),
    .AMT_WIDTH  (AW),
    .STEP       (STEP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SHIFT_SEQ_FLUSH_EN
    .flush      (flush),
`endif
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_value  (req_value),
    .req_amount (req_amount),
    .req_shift  (req_shift),
    .req_carry  (req_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_value  (rsp_value),
    .rsp_carry  (rsp_carry),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ARM shifter result {carry, value} for shift type typ by amt bits.
  function automatic logic [32:0] ref_shift(input logic [31:0] v, input int amt, input int typ,
                                            input logic cin);
    logic [63:0] wide;
    logic [31:0] sv;
    int m;
    if (amt == 0) return {cin, v};
    case (typ)
      0: begin
        if (amt < 32) return {v[32-amt], v << amt};
        else if (amt == 32) return {v[0], 32'h0};
        else return 33'h0;
      end
      1: begin
        if (amt < 32) return {v[amt-1], v >> amt};
        else if (amt == 32) return {v[31], 32'h0};
        else return 33'h0;
      end
      2: begin
        if (amt >= 32) return {v[31], {32{v[31]}}};
        sv = 32'($signed(v) >>> amt);
        return {v[amt-1], sv};
      end
      default: begin
        m = amt % 32;
        if (m == 0) return {v[31], v};
        wide = {v, v} >> m;
        return {v[m-1], wide[31:0]};
      end
    endcase
  endfunction

  function automatic int ref_latency(input int amt, input int typ);
    int n;
    if (typ == 3) n = ((amt % 32 == 0) && (amt != 0)) ? 32 : amt % 32;
    else n = (amt > 33) ? 33 : amt;
    return (n + STEP - 1) / STEP + 1;
  endfunction

  // Issue one request (called at a negedge), collect the response, optionally hold and retire it.
  task automatic run_op(input string tag, input logic [31:0] v, input int amt, input int typ,
                        input logic cin, input int hold, input bit retire);
    logic [32:0] exp;
    logic [31:0] held_v;
    logic        held_c;
    int          lat;
    int          cnt;
    exp = ref_shift(v, amt, typ, cin);
    lat = ref_latency(amt, typ);
    req_value  = v;
    req_amount = AW'(amt);
    req_shift  = 2'(typ);
    req_carry  = cin;
    req_valid  = 1'b1;
    rsp_ready  = 1'b1;
    cnt = 0;
    #1;
    while (!req_ready && cnt < 100) begin
      @(negedge clk); #1;
      cnt++;
    end
    check($sformatf("%s_accept_wait", tag), 32'(cnt), 32'd0);
    if (!req_ready) begin
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    rsp_ready  = 1'b0;
    req_value  = $urandom;
    req_amount = AW'($urandom);
    req_carry  = ~cin;
    check($sformatf("%s_busy", tag), 32'(busy), 32'd1);
    cnt = 1;
    while (!rsp_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check($sformatf("%s_latency", tag), 32'(cnt), 32'(lat));
    check($sformatf("%s_value", tag), rsp_value, exp[31:0]);
    check($sformatf("%s_carry", tag), 32'(rsp_carry), 32'(exp[32]));
    held_v = rsp_value;
    held_c = rsp_carry;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s_hold_value", tag), {rsp_value[30:0], rsp_carry} ^ 32'(rsp_valid),
            {held_v[30:0], held_c} ^ 32'd1);
      check($sformatf("%s_hold_ready", tag), 32'(req_ready), 32'd0);
    end
    if (retire) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check($sformatf("%s_retire_valid", tag), 32'(rsp_valid), 32'd0);
      check($sformatf("%s_retire_busy", tag), 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int amt;
    int typ;
    int pick;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_value  = '0;
    req_amount = '0;
    req_shift  = '0;
    req_carry  = 1'b0;
    rsp_ready  = 1'b0;
`ifdef SHIFT_SEQ_FLUSH_EN
    flush      = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_value", rsp_value, 32'd0);
    check("reset_carry", 32'(rsp_carry), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("lsl4", 32'hF000_000F, 4, 0, 1'b0, 0, 1'b1);
    run_op("lsr32", 32'h8000_0001, 32, 1, 1'b0, 0, 1'b1);
    run_op("lsr33", 32'h8000_0001, 33, 1, 1'b1, 0, 1'b1);
    run_op("asr200", 32'h8000_0000, 200, 2, 1'b0, 0, 1'b1);
    run_op("ror0", 32'h1234_5678, 0, 3, 1'b1, 0, 1'b1);
    run_op("ror64", 32'h8000_0001, 64, 3, 1'b0, 0, 1'b1);
    run_op("lsl32", 32'h0000_0001, 32, 0, 1'b0, 0, 1'b1);
    run_op("hold3", 32'hA5A5_0F0F, 7, 3, 1'b0, 3, 1'b0);
    run_op("b2b", 32'h0000_8001, 3, 1, 1'b1, 1, 1'b1);

    // Reset pulse in the middle of a long shift.
    req_value  = 32'hFFFF_FFFF;
    req_amount = AW'(20);
    req_shift  = 2'd0;
    req_carry  = 1'b1;
    req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_value", rsp_value, 32'd0);
    check("rst_mid_carry", 32'(rsp_carry), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_rst", 32'hFFFF_FFFF, 20, 0, 1'b0, 0, 1'b1);

`ifdef SHIFT_SEQ_FLUSH_EN
    // Flush mid-shift while a new request is waiting.
    req_value  = 32'h0F0F_0F0F;
    req_amount = AW'(10);
    req_shift  = 2'd0;
    req_carry  = 1'b0;
    req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    repeat (3) @(negedge clk);
    flush      = 1'b1;
    req_value  = 32'h1357_9BDF;
    req_amount = AW'(5);
    req_shift  = 2'd1;
    #1;
    check("flush_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_valid", 32'(rsp_valid), 32'd0);
    run_op("post_flush", 32'h1357_9BDF, 5, 1, 1'b0, 0, 1'b1);
`endif

    for (int i = 0; i < 80; i++) begin
      pick = int'($urandom_range(0, 3));
      typ  = int'($urandom_range(0, 3));
      case (pick)
        0: begin
          case ($urandom_range(0, 6))
            0: amt = 0;
            1: amt = 1;
            2: amt = 31;
            3: amt = 32;
            4: amt = 33;
            5: amt = 64;
            default: amt = 255;
          endcase
        end
        1: amt = int'($urandom_range(0, 255));
        default: amt = int'($urandom_range(0, 40));
      endcase
      run_op($sformatf("rnd%0d", i), $urandom, amt, typ, 1'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
